// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle in RUN, then a sign fix-up cycle before DONE.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] r_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_want_rem;
    logic [WIDTH-1:0] r_result;

    logic             w_is_signed;
    logic             w_want_rem;
    logic             w_div_zero;
    logic             w_overflow;
    logic             w_launch;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_sub;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;
    logic             w_unused_f3;

    assign w_is_signed = ~funct3[0];
    assign w_want_rem  = funct3[1];
    assign w_unused_f3 = funct3[2];
    assign w_div_zero  = (b == '0);
    assign w_overflow  = w_is_signed && (a == MIN_INT) && (b == '1);
    assign w_launch    = (r_state == S_IDLE) && start;

    assign w_abs_a = (w_is_signed && a[WIDTH-1]) ? ({WIDTH{1'b0}} - a) : a;
    assign w_abs_b = (w_is_signed && b[WIDTH-1]) ? ({WIDTH{1'b0}} - b) : b;

    // The remainder is one bit wider than the divisor only for the compare;
    // after a successful subtract it always fits back into WIDTH bits.
    assign w_shift = {r_r, r_q[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_div});
    assign w_sub   = w_shift[WIDTH-1:0] - r_div;

    assign w_q_fix = r_neg_q ? ({WIDTH{1'b0}} - r_q) : r_q;
    assign w_r_fix = r_neg_r ? ({WIDTH{1'b0}} - r_r) : r_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (start) w_state_nxt = (w_div_zero || w_overflow) ? S_DONE : S_RUN;
            S_RUN:  if (r_count == '0) w_state_nxt = S_FIX;
            S_FIX:  w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_q        <= '0;
            r_r        <= '0;
            r_div      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_want_rem <= 1'b0;
            r_result   <= '0;
        end else if (w_launch) begin
            r_want_rem <= w_want_rem;
            if (w_div_zero) begin
                r_q      <= '1;
                r_r      <= a;
                r_result <= w_want_rem ? a : '1;
            end else if (w_overflow) begin
                r_q      <= MIN_INT;
                r_r      <= '0;
                r_result <= w_want_rem ? '0 : MIN_INT;
            end else begin
                r_q     <= w_abs_a;
                r_r     <= '0;
                r_div   <= w_abs_b;
                r_neg_q <= w_is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                r_neg_r <= w_is_signed && a[WIDTH-1];
                r_count <= CW'(WIDTH - 1);
            end
        end else if (r_state == S_RUN) begin
            r_q <= {r_q[WIDTH-2:0], w_ge};
            r_r <= w_ge ? w_sub : w_shift[WIDTH-1:0];
            if (r_count != '0) r_count <= r_count - CW'(1);
        end else if (r_state == S_FIX) begin
            r_q      <= w_q_fix;
            r_r      <= w_r_fix;
            r_result <= r_want_rem ? w_r_fix : w_q_fix;
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE);
    assign result = r_result;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: table of hand-computed results plus
// mid-run start, mid-run reset and a randomized sweep against a reference model.
module tb_div_unit;

    localparam int W = 32;
    localparam logic [2:0] F_DIV  = 3'b100;
    localparam logic [2:0] F_DIVU = 3'b101;
    localparam logic [2:0] F_REM  = 3'b110;
    localparam logic [2:0] F_REMU = 3'b111;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [2:0]   funct3;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        string        name;
        logic [2:0]   f;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        int           lat;
    } vec_t;

    vec_t vecs[$];

    div_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic [2:0] f, input logic [W-1:0] av,
                           input logic [W-1:0] bv, input logic [W-1:0] exp, input int lat);
        vec_t v;
        v.name = name; v.f = f; v.a = av; v.b = bv; v.exp = exp; v.lat = lat;
        vecs.push_back(v);
    endtask

    // Launch one op and wait for done; inputs are scrambled after the start cycle.
    task automatic run_op(input logic [2:0] f, input logic [W-1:0] av, input logic [W-1:0] bv,
                          output logic [W-1:0] res, output int lat, output bit busy_ok);
        @(negedge clk);
        funct3 = f; a = av; b = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; funct3 = 3'($urandom_range(4, 7));
        lat = 1;
        busy_ok = 1'b1;
        while (!done && lat < 100) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (!busy) busy_ok = 1'b0;
        if (!done) lat = -1;
        res = result;
    endtask

    function automatic logic [W-1:0] ref_model(input logic [2:0] f, input logic [W-1:0] av,
                                               input logic [W-1:0] bv);
        logic signed [W-1:0] sa, sb;
        sa = av; sb = bv;
        if (bv == '0) return f[1] ? av : '1;
        if (!f[0]) begin
            if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) return f[1] ? '0 : 32'h8000_0000;
            return f[1] ? W'(sa % sb) : W'(sa / sb);
        end
        return f[1] ? (av % bv) : (av / bv);
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [W-1:0] res;
        logic [W-1:0] exp;
        logic [W-1:0] held;
        int           lat;
        int           cnt;
        bit           busy_ok;
        bit           saw_done;
        logic [2:0]   rf;
        logic [W-1:0] ra, rb;

        add_vec("div_100_7",      F_DIV,  32'd100,        32'd7,          32'd14,         34);
        add_vec("rem_100_7",      F_REM,  32'd100,        32'd7,          32'd2,          34);
        add_vec("div_m7_2",       F_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34);
        add_vec("rem_m7_2",       F_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34);
        add_vec("rem_7_m2",       F_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          34);
        add_vec("div_7_m2",       F_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  34);
        add_vec("divu_max_2",     F_DIVU, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  34);
        add_vec("remu_max_2",     F_REMU, 32'hFFFF_FFFF,  32'd2,          32'd1,          34);
        add_vec("div_m1_2",       F_DIV,  32'hFFFF_FFFF,  32'd2,          32'd0,          34);
        add_vec("div_5_0",        F_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1);
        add_vec("remu_5_0",       F_REMU, 32'd5,          32'd0,          32'd5,          1);
        add_vec("rem_m5_0",       F_REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1);
        add_vec("div_ovf",        F_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1);
        add_vec("rem_ovf",        F_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1);
        add_vec("divu_min_m1",    F_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34);
        add_vec("div_m100_m7",    F_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         34);
        add_vec("rem_m100_m7",    F_REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  34);
        add_vec("div_min_1",      F_DIV,  32'h8000_0000,  32'd1,          32'h8000_0000,  34);
        add_vec("rem_min_3",      F_REM,  32'h8000_0000,  32'd3,          32'hFFFF_FFFE,  34);
        add_vec("divu_max_max",   F_DIVU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          34);
        add_vec("remu_16_17",     F_REMU, 32'd16,         32'd17,         32'd16,         34);
        add_vec("rem_0_m1",       F_REM,  32'd0,          32'hFFFF_FFFF,  32'd0,          34);

        rst_n = 1'b0; start = 1'b0; funct3 = F_DIV; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("reset_busy",   W'(busy),   '0);
        check("reset_done",   W'(done),   '0);
        check("reset_result", result,     '0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            exp_q.push_back(vecs[i].exp);
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, res, lat, busy_ok);
            exp = exp_q.pop_front();
            check({vecs[i].name, "_result"}, res, exp);
            check({vecs[i].name, "_latency"}, W'(lat), W'(vecs[i].lat));
            check({vecs[i].name, "_busy"}, W'(busy_ok), W'(1));
        end

        // done is a single pulse and result holds afterwards
        run_op(F_DIV, 32'd100, 32'd7, res, lat, busy_ok);
        held = res;
        @(negedge clk);
        check("done_pulse_off", W'(done), '0);
        check("busy_off_after", W'(busy), '0);
        repeat (4) @(negedge clk);
        check("result_held", result, held);

        // a second start while RUN must be ignored
        @(negedge clk);
        funct3 = F_DIV; a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 1;
        repeat (9) begin @(negedge clk); cnt++; end
        funct3 = F_REM; a = 32'd9; b = 32'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt++;
        while (!done && cnt < 100) begin @(negedge clk); cnt++; end
        check("ignore_start_result", result, 32'd14);
        check("ignore_start_latency", W'(cnt), W'(34));

        // reset in the middle of RUN aborts without a done pulse
        @(negedge clk);
        funct3 = F_DIV; a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", W'(busy), '0);
        check("abort_done", W'(done), '0);
        saw_done = 1'b0;
        repeat (3) begin @(negedge clk); if (done) saw_done = 1'b1; end
        rst_n = 1'b1;
        repeat (40) begin @(negedge clk); if (done || busy) saw_done = 1'b1; end
        check("abort_no_done", W'(saw_done), '0);
        check("abort_result_clear", result, '0);
        run_op(F_DIV, 32'd100, 32'd7, res, lat, busy_ok);
        check("after_abort_result", res, 32'd14);
        check("after_abort_latency", W'(lat), W'(34));

        // randomized sweep against the reference model
        for (int i = 0; i < 40; i++) begin
            rf = 3'($urandom_range(4, 7));
            ra = pick_operand();
            rb = pick_operand();
            exp_q.push_back(ref_model(rf, ra, rb));
            run_op(rf, ra, rb, res, lat, busy_ok);
            exp = exp_q.pop_front();
            if (res !== exp)
                $display("  op f=%b a=%h b=%h", rf, ra, rb);
            check($sformatf("rand%0d_result", i), res, exp);
            check($sformatf("rand%0d_busy", i), W'(busy_ok), W'(1));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
